// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round-count function, FSM state type and
// byte/key slicing helpers used by aes_encrypt_iter and aes_round.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 at the MSBs.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic int nr_for_nk(input int nk);
    case (nk)
      4:       return 10;
      6:       return 12;
      8:       return 14;
      default: return 10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte idx of a block; byte 0 sits at the MSBs.
  function automatic logic [7:0] blk_byte(input logic [AES_BLK_W-1:0] blk, input int idx);
    return blk[AES_BLK_W-1-8*idx -: 8];
  endfunction

  // LSB offset of round key idx in a bus holding keys 0..nr, key 0 at the MSBs.
  function automatic int rk_lsb(input int nr, input int idx);
    return (nr - idx) * AES_BLK_W;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// final_round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 final_round,
  output logic [AES_BLK_W-1:0] next_state
);

  logic [AES_BLK_W-1:0] sub_s;
  logic [AES_BLK_W-1:0] shift_s;
  logic [AES_BLK_W-1:0] mix_s;

  // Round transform; state is column-major, byte r+4c is row r of column c.
  always_comb begin
    sub_s      = '0;
    shift_s    = '0;
    mix_s      = '0;
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      sub_s[AES_BLK_W-1-8*i -: 8] = sbox(blk_byte(state, i));
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[AES_BLK_W-1-8*(4*c+r) -: 8] = blk_byte(sub_s, 4*((c+r)%4) + r);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_s[AES_BLK_W-1-32*c -: 32] = mix_column(shift_s[AES_BLK_W-1-32*c -: 32]);
    end
    if (final_round) begin
      next_state = shift_s ^ round_key;
    end else begin
      next_state = mix_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption engine, one round per enabled clock.
// Optional macro AES_KEY_LATCH_EN captures the round-key bus at accept.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter  int NK     = 4,
  localparam int NR     = nr_for_nk(NK),
  localparam int KEYS_W = (NR + 1) * AES_BLK_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic [KEYS_W-1:0]    round_keys,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_encrypt_iter: NK must be 4, 6 or 8");
  end

  aes_state_e           state_r;
  aes_state_e           state_next_s;
  logic [3:0]           cnt_r;
  logic [AES_BLK_W-1:0] blk_r;
  logic [AES_BLK_W-1:0] out_data_r;
  logic [KEYS_W-1:0]    keys_s;
  logic [AES_BLK_W-1:0] round_key_s;
  logic [AES_BLK_W-1:0] round_next_s;
  logic                 final_s;
  logic                 accept_s;

  assign accept_s    = enable && in_valid && (state_r == IDLE);
  assign final_s     = (cnt_r == 4'(NR));
  assign round_key_s = keys_s[rk_lsb(NR, int'(cnt_r)) +: AES_BLK_W];

`ifdef AES_KEY_LATCH_EN
  logic [KEYS_W-1:0] keys_r;

  // Snapshot of the whole key schedule taken at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_r <= '0;
    end else if (accept_s) begin
      keys_r <= round_keys;
    end
  end

  assign keys_s = keys_r;
`else
  assign keys_s = round_keys;
`endif

  aes_round u_round (
    .state       (blk_r),
    .round_key   (round_key_s),
    .final_round (final_s),
    .next_state  (round_next_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; enable=0 freezes every transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ROUND;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROUND: begin
        if (enable && final_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ROUND;
        end
      end
      DONE: begin
        if (enable && out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: initial AddRoundKey, per-round update and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_r      <= '0;
      cnt_r      <= 4'd0;
      out_data_r <= '0;
    end else if (enable) begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            blk_r <= in_data ^ round_keys[KEYS_W-1 -: AES_BLK_W];
            cnt_r <= 4'd1;
          end
        end
        ROUND: begin
          blk_r <= round_next_s;
          if (final_s) begin
            out_data_r <= round_next_s;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          blk_r <= blk_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == ROUND);
  assign out_valid = (state_r == DONE);
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using the FIPS-197 appendix C vectors
// for NK=4/6/8, plus backpressure, stall, mid-round reset and key-latch cases.
module tb_aes_encrypt_iter;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset, enable;
  logic [127:0] in_data;
  logic in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [127:0] out_data4;
  logic [1407:0] k4;
  logic in_valid68, out_ready68;
  logic in_ready6, out_valid6, busy6, in_ready8, out_valid8, busy8;
  logic [127:0] out_data6, out_data8;
  logic [1663:0] k6;
  logic [1919:0] k8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.NK(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .round_keys(k4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .busy(busy4));

  aes_encrypt_iter #(.NK(6)) dut6 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid68), .in_ready(in_ready6),
    .in_data(in_data), .round_keys(k6), .out_valid(out_valid6), .out_ready(out_ready68),
    .out_data(out_data6), .busy(busy6));

  aes_encrypt_iter #(.NK(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid68), .in_ready(in_ready8),
    .in_data(in_data), .round_keys(k8), .out_valid(out_valid8), .out_ready(out_ready68),
    .out_data(out_data8), .busy(busy8));

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {aes_pkg::sbox(w[31:24]), aes_pkg::sbox(w[23:16]),
            aes_pkg::sbox(w[15:8]), aes_pkg::sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion of key bytes 00,01,02,...; word 0 at the MSBs.
  function automatic logic [1919:0] expand_key(input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] bus;
    int            nw;
    nw  = 4 * (nk + 7);
    rc  = 8'h01;
    bus = '0;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      bus[1919-32*i -: 32] = w[i];
    end
    return bus;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer PT to the NK=4 engine for one accept edge.
  task automatic accept4();
    in_data   = PT;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
  endtask

  // Count enabled edges until out_valid4 rises (bounded).
  task automatic wait_valid4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid4 && n < 40);
  endtask

  logic [1919:0] full;
  int n, n6, n8;

  initial begin
    full = expand_key(4); k4 = full[1919 -: 1408];
    full = expand_key(6); k6 = full[1919 -: 1664];
    full = expand_key(8); k8 = full;
    reset = 1'b1; enable = 1'b1; in_data = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; in_valid68 = 1'b0; out_ready68 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 128'(in_ready4), 128'd1);
    chk("rst_out_valid", 128'(out_valid4), 128'd0);
    chk("rst_busy", 128'(busy4), 128'd0);
    chk("rst_out_data", out_data4, 128'd0);
    chk("rst_in_ready8", 128'(in_ready8), 128'd1);

    // NK=4 basic encryption and latency
    accept4();
    chk("acc_busy", 128'(busy4), 128'd1);
    chk("acc_in_ready", 128'(in_ready4), 128'd0);
    wait_valid4(n);
    chk("nk4_latency", 128'(n), 128'd10);
    chk("nk4_data", out_data4, CT4);
    tick();
    chk("nk4_idle_in_ready", 128'(in_ready4), 128'd1);
    chk("nk4_idle_out_valid", 128'(out_valid4), 128'd0);
    chk("nk4_data_hold", out_data4, CT4);

    // Backpressure for 20 cycles, then a second block
    out_ready4 = 1'b0;
    accept4();
    wait_valid4(n);
    chk("bp_latency", 128'(n), 128'd10);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid4), 128'd1);
      chk("bp_out_data", out_data4, CT4);
      chk("bp_in_ready", 128'(in_ready4), 128'd0);
    end
    out_ready4 = 1'b1;
    tick();
    chk("bp_release_in_ready", 128'(in_ready4), 128'd1);
    accept4();
    wait_valid4(n);
    chk("second_latency", 128'(n), 128'd10);
    chk("second_data", out_data4, CT4);
    tick();

    // Stall for 5 cycles mid-ROUND
    accept4();
    tick(); tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_busy", 128'(busy4), 128'd1);
      chk("stall_out_valid", 128'(out_valid4), 128'd0);
    end
    enable = 1'b1;
    wait_valid4(n);
    chk("stall_remaining", 128'(n), 128'd7);
    chk("stall_data", out_data4, CT4);
    tick();

    // Reset at round 4 aborts the block
    accept4();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("mrst_out_valid", 128'(out_valid4), 128'd0);
    chk("mrst_out_data", out_data4, 128'd0);
    chk("mrst_in_ready", 128'(in_ready4), 128'd1);
    chk("mrst_busy", 128'(busy4), 128'd0);
    reset = 1'b0;
    accept4();
    wait_valid4(n);
    chk("post_rst_latency", 128'(n), 128'd10);
    chk("post_rst_data", out_data4, CT4);
    tick();

    // NK=6 and NK=8 in parallel, held in DONE by out_ready68=0
    in_data    = PT;
    in_valid68 = 1'b1;
    tick();
    in_valid68 = 1'b0;
    n6 = 0; n8 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid6 && n6 == 0) n6 = i;
      if (out_valid8 && n8 == 0) n8 = i;
    end
    chk("nk6_latency", 128'(n6), 128'd12);
    chk("nk6_data", out_data6, CT6);
    chk("nk8_latency", 128'(n8), 128'd14);
    chk("nk8_data", out_data8, CT8);
    out_ready68 = 1'b1;
    tick();
    chk("nk8_idle", 128'(in_ready8), 128'd1);

`ifdef AES_KEY_LATCH_EN
    // Keys corrupted one cycle after accept
    accept4();
    tick();
    k4 = '1;
    wait_valid4(n);
    chk("latch_latency", 128'(n), 128'd9);
    chk("latch_data", out_data4, CT4);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
Parametrised iterative AES encryption engine; successor to the fixed AES-128 encryption_block.
- Supports AES-128/192/256 through one key-length parameter.
- Takes a fully expanded round-key bus from the key-expansion stage.
- One round per clock; ready/valid handshakes on input and output, plus a stall enable.
- Sits between the key schedule and the mode/packet logic in the crypto datapath.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
NR, NK+6 (localparam), number of rounds: 10, 12 or 14.
KEYS_W, (NR+1)*128 (localparam), width of the round-key bus.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  global advance; when 0, all state is frozen.
in_valid  input  1  plaintext block offered.
in_ready  output  1  engine can accept a block.
in_data  input  128  plaintext; byte 0 is at bits [127:120].
round_keys  input  KEYS_W  expanded keys; round key 0 at the MSBs, key NR at the LSBs.
out_valid  output  1  ciphertext available.
out_ready  input  1  downstream accepts the ciphertext.
out_data  output  128  ciphertext, same byte order as in_data.
busy  output  1  high while rounds are in progress (ROUND state).

Behaviour:
- Reset (synchronous, active-high, overrides enable): state=IDLE, round counter=0, state register=0.
  - Output reset values: out_valid=0, out_data=0, busy=0, in_ready=1.
- FSM states: IDLE, ROUND, DONE.
- Nothing advances when enable=0:
  - no handshake completes; state, counter and outputs hold.
  - in_ready and out_valid keep their registered/state-derived values.
- IDLE: in_ready=1.
  - On an edge with in_valid & enable: state reg <= in_data ^ key0; counter <= 1; go to ROUND.
- ROUND: in_ready=0, busy=1.
  - Each enabled edge applies round[counter] = SubBytes, ShiftRows, MixColumns, AddRoundKey(key[counter]).
  - The round where counter==NR omits MixColumns, loads out_data, sets out_valid=1 and moves to DONE.
- Latency: out_valid rises exactly NR enabled edges after the accept edge (10/12/14).
- DONE: out_valid=1, out_data stable, in_ready=0.
  - On an edge with out_ready & enable: out_valid <= 0; go to IDLE.
  - Throughput is one block per NR+2 cycles minimum.
- out_data holds its last value after the handshake until the next completion or a reset.
- round_keys must stay stable from the accept edge to completion, unless AES_KEY_LATCH_EN is defined.
- Reset mid-operation (ROUND or DONE): the block is aborted with no output; reset values apply on the next cycle.
- in_valid while busy: ignored and not buffered; the source must hold it until in_ready.
- Counter width is 4 bits; no wrap occurs because the maximum value is 14.

Optional Feature:
Macro: AES_KEY_LATCH_EN.
- Defined: at the accept edge the entire round_keys bus is captured into an internal KEYS_W register, and rounds use the captured copy. The round_keys input may change freely after accept. The register is cleared on reset.
- Not defined: rounds index round_keys combinationally with no extra storage. The caller must hold keys stable; changing them mid-block produces undefined ciphertext.

Decomposition:
- Shared package aes_pkg:
  - S-box constant table.
  - Round-count function nr_for_nk(NK).
  - Block width constant AES_BLK_W=128.
  - FSM state enum (IDLE/ROUND/DONE).
  - Byte-slice helpers for key indexing.
- Natural sub-module: aes_round. Combinational; inputs are state, round key and a final flag (skips MixColumns); output is the next state. The FSM, counter, handshakes and key latch stay in aes_encrypt_iter.

Test Plan:
- NK=4: key 000102..0f expanded; in_data 00112233445566778899aabbccddeeff; out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
- NK=6: key 000102..17, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 edges. NK=8: key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
- Backpressure: out_ready=0 for 20 cycles after completion -> out_valid and out_data held, in_ready=0. Then out_ready=1 -> IDLE, and a second block is accepted and correct.
- Stall: enable=0 for 5 cycles mid-ROUND -> counter and busy frozen; out_valid appears 5 cycles later with the correct ciphertext.
- Reset mid-round (asserted at round 4, NK=4) -> next cycle out_valid=0, out_data=0, in_ready=1, busy=0. A fresh block then encrypts correctly.
- With AES_KEY_LATCH_EN: corrupt round_keys to all-ones one cycle after accept -> ciphertext still 69c4e0d8...c55a. Without the macro this test is skipped.
